// File: rtl/seg_pkg.sv
// Shared types and helpers for the four-digit multiplexed 7-segment scan controller.
package seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    SHOW = 2'd2
  } state_e;

  function automatic logic [3:0] digit_of(input logic [15:0] d, input logic [1:0] k);
    return d[4*k +: 4];
  endfunction

  function automatic logic any_invalid(input logic [15:0] d);
    logic bad;
    bad = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (digit_of(d, 2'(j)) > BCD_MAX) bad = 1'b1;
    end
    return bad;
  endfunction

  // Non-BCD digits are always dark; with lzb, a zero digit is dark when every higher digit is zero too.
  function automatic logic digit_blank(input logic [15:0] d, input logic [1:0] k, input logic lzb);
    logic blank;
    logic hi_zero;
    blank   = (digit_of(d, k) > BCD_MAX);
    hi_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(k) && digit_of(d, 2'(j)) != 4'd0) hi_zero = 1'b0;
    end
    if (lzb && k != 2'd0 && hi_zero) blank = 1'b1;
    return blank;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Bus between the scan controller and its user / the external segment decoder and anode drivers.
interface seven_seg_scan_ctrl_if;
  import seg_pkg::*;

  logic                      en;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic                      lzb;
  logic [0:3]                bcd_out;
  logic [NUM_DIGITS-1:0]     an_n;
  logic                      frame_done;
  logic                      bcd_err;

  modport master (
    output en, load, digits_in, lzb,
    input  bcd_out, an_n, frame_done, bcd_err
  );

  modport slave (
    input  en, load, digits_in, lzb,
    output bcd_out, an_n, frame_done, bcd_err
  );

endinterface

// File: rtl/seven_seg_scan_ctrl_scan_timer.sv
// Loadable down-counter timing one DEAD or SHOW slot; done flags the last cycle of the slot.
module scan_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             done_o,
  output logic             done_nxt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at zero so the count never wraps inside a slot.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o     = (cnt_q == '0);
  assign done_nxt_o = (cnt_d == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan of four BCD digits: anodes-off guard, then one digit lit per slot.
module seven_seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SHOW_CYC = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seven_seg_scan_ctrl_if.slave bus
);

  localparam int MAX_CYC = (SHOW_CYC > DEAD_CYC) ? SHOW_CYC : DEAD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [1:0]       LAST_IDX  = 2'(NUM_DIGITS - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] pending_q, pending_d;
  logic [15:0] active_q, active_d;
  logic [3:0]  bcd_q, bcd_d;
  logic [3:0]  an_n_q, an_n_d;
  logic        fd_q, fd_d;
  logic        err_q, err_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             tmr_done_nxt;

  scan_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .val_i      (tmr_val),
    .done_o     (tmr_done),
    .done_nxt_o (tmr_done_nxt)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    active_d  = active_q;
    err_d     = err_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    if (bus.load) begin
      pending_d = bus.digits_in;
      if (any_invalid(bus.digits_in)) err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d  = DEAD;
          idx_d    = 2'd0;
          tmr_load = 1'b1;
          tmr_val  = DEAD_LAST;
        end
      end
      DEAD: begin
        if (!bus.en) begin
          state_d  = IDLE;
          idx_d    = 2'd0;
          tmr_load = 1'b1;
        end else if (tmr_done) begin
          state_d  = SHOW;
          tmr_load = 1'b1;
          tmr_val  = SHOW_LAST;
        end
      end
      SHOW: begin
        if (!bus.en) begin
          state_d  = IDLE;
          idx_d    = 2'd0;
          tmr_load = 1'b1;
        end else if (tmr_done) begin
          state_d  = DEAD;
          idx_d    = idx_q + 2'd1;
          tmr_load = 1'b1;
          tmr_val  = DEAD_LAST;
        end
      end
      default: begin
        state_d  = IDLE;
        idx_d    = 2'd0;
        tmr_load = 1'b1;
      end
    endcase

    // New digits take effect only at a frame boundary; a coincident load bypasses pending.
    if (state_d == DEAD && idx_d == 2'd0 && state_q != DEAD) begin
      active_d = bus.load ? bus.digits_in : pending_q;
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    bcd_d  = digit_of(active_d, idx_d);
    an_n_d = 4'hF;
    if (state_d == SHOW && !digit_blank(active_d, idx_d, bus.lzb)) begin
      an_n_d[idx_d] = 1'b0;
    end
    fd_d = (state_d == SHOW) && (idx_d == LAST_IDX) && tmr_done_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      pending_q <= '0;
      active_q  <= '0;
      bcd_q     <= '0;
      an_n_q    <= 4'hF;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      bcd_q     <= bcd_d;
      an_n_q    <= an_n_d;
      fd_q      <= fd_d;
      err_q     <= err_d;
    end
  end

  // bcd_out is declared [0:3] with element 0 carrying weight 1.
  assign bus.bcd_out    = {bcd_q[0], bcd_q[1], bcd_q[2], bcd_q[3]};
  assign bus.an_n       = an_n_q;
  assign bus.frame_done = fd_q;
  assign bus.bcd_err    = err_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with SHOW_CYC=4, DEAD_CYC=1 (5-cycle slots, 20-cycle frames).
module tb_seven_seg_scan_ctrl;

  localparam int SHOW_C = 4;
  localparam int DEAD_C = 1;
  localparam int SLOT   = SHOW_C + DEAD_C;
  localparam int FRAME  = 4 * SLOT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_scan_ctrl_if bus ();

  seven_seg_scan_ctrl #(
    .SHOW_CYC (SHOW_C),
    .DEAD_CYC (DEAD_C)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] bcd;
    logic       fd;
    logic       err;
    logic       chk_bcd;
  } exp_t;

  typedef struct {
    logic [15:0] digits;
    logic        lzb;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_bad   = 0;
  logic err_exp = 1'b0;

  function automatic logic [3:0] dig(input logic [15:0] a, input int k);
    logic [15:0] s;
    s = a >> (4 * k);
    return s[3:0];
  endfunction

  function automatic logic blanked(input logic [15:0] a, input int k, input logic lzb);
    if (dig(a, k) > 4'd9) return 1'b1;
    if (!lzb || k == 0) return 1'b0;
    for (int j = k; j < 4; j++) begin
      if (dig(a, j) != 4'd0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Expected outputs t cycles after the scan was (re)started, with digits a on display.
  function automatic exp_t frame_exp(input logic [15:0] a, input int t, input logic lzb, input logic err);
    exp_t e;
    int   slot;
    int   p;
    slot      = (t % FRAME) / SLOT;
    p         = t % SLOT;
    e.an      = 4'hF;
    if (p >= DEAD_C && !blanked(a, slot, lzb)) e.an[slot] = 1'b0;
    e.bcd     = dig(a, slot);
    e.fd      = (slot == 3) && (p == SLOT - 1);
    e.err     = err;
    e.chk_bcd = 1'b1;
    return e;
  endfunction

  function automatic exp_t idle_exp(input logic err);
    exp_t e;
    e.an      = 4'hF;
    e.bcd     = 4'h0;
    e.fd      = 1'b0;
    e.err     = err;
    e.chk_bcd = 1'b0;
    return e;
  endfunction

  function automatic logic [3:0] dut_bcd();
    return {bus.bcd_out[3], bus.bcd_out[2], bus.bcd_out[1], bus.bcd_out[0]};
  endfunction

  task automatic compare(input string name, input exp_t req);
    logic [3:0] b;
    b = req.chk_bcd ? dut_bcd() : 4'h0;
    n_vec++;
    if (bus.an_n !== req.an || b !== req.bcd || bus.frame_done !== req.fd || bus.bcd_err !== req.err) begin
      n_bad++;
      $display("FAIL %s: got an_n=%b bcd=%h fd=%b err=%b, expected an_n=%b bcd=%h fd=%b err=%b",
               name, bus.an_n, b, bus.frame_done, bus.bcd_err, req.an, req.bcd, req.fd, req.err);
    end
  endtask

  task automatic drive(input logic en, input logic ld, input logic [15:0] d, input logic lzb);
    bus.en        = en;
    bus.load      = ld;
    bus.digits_in = d;
    bus.lzb       = lzb;
    if (ld) begin
      for (int k = 0; k < 4; k++) if (dig(d, k) > 4'd9) err_exp = 1'b1;
    end
  endtask

  // Push the expectation for the state after the next edge, then pop and check it there.
  task automatic cyc(input string name, input exp_t e);
    exp_t x;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    compare(name, x);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    drive(1'b0, 1'b0, 16'h0, v.lzb);
    cyc($sformatf("v%0d_idle", i), idle_exp(err_exp));
    drive(1'b1, 1'b1, v.digits, v.lzb);
    cyc($sformatf("v%0d_t0", i), frame_exp(v.digits, 0, v.lzb, err_exp));
    drive(1'b1, 1'b0, 16'hFFFF, v.lzb);
    for (int t = 1; t < 2 * FRAME; t++) begin
      cyc($sformatf("v%0d_t%0d", i, t), frame_exp(v.digits, t, v.lzb, err_exp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t        vecs[6];
    logic [15:0] a;
    logic        ld;
    logic [15:0] d;

    vecs[0] = '{digits: 16'h1234, lzb: 1'b0};
    vecs[1] = '{digits: 16'h0007, lzb: 1'b1};
    vecs[2] = '{digits: 16'h00A5, lzb: 1'b0};
    vecs[3] = '{digits: 16'h0000, lzb: 1'b1};
    vecs[4] = '{digits: 16'h0990, lzb: 1'b1};
    vecs[5] = '{digits: 16'hA0F3, lzb: 1'b0};

    drive(1'b0, 1'b0, 16'h0, 1'b0);
    #12;
    compare("reset", '{an: 4'hF, bcd: 4'h0, fd: 1'b0, err: 1'b0, chk_bcd: 1'b1});
    #1 rst_n = 1'b1;
    cyc("post_reset_idle", '{an: 4'hF, bcd: 4'h0, fd: 1'b0, err: 1'b0, chk_bcd: 1'b1});

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Mid-frame load, load coincident with the frame transfer, then en dropped mid-SHOW.
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    cyc("mid_idle", idle_exp(err_exp));
    drive(1'b1, 1'b1, 16'h1234, 1'b0);
    cyc("mid_t0", frame_exp(16'h1234, 0, 1'b0, err_exp));
    for (int t = 1; t < 67; t++) begin
      a  = (t < FRAME) ? 16'h1234 : (t < 2 * FRAME) ? 16'h9999 : 16'h5678;
      ld = (t == 8) || (t == 2 * FRAME);
      d  = (t == 8) ? 16'h9999 : 16'h5678;
      drive(1'b1, ld, d, 1'b0);
      cyc($sformatf("mid_t%0d", t), frame_exp(a, t, 1'b0, err_exp));
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    cyc("en_drop", idle_exp(err_exp));
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    for (int t = 0; t < 12; t++) begin
      cyc($sformatf("restart_t%0d", t), frame_exp(16'h5678, t, 1'b0, err_exp));
    end

    // Asynchronous reset while digit 2 is lit.
    #2 rst_n = 1'b0;
    err_exp = 1'b0;
    #1;
    compare("async_reset", '{an: 4'hF, bcd: 4'h0, fd: 1'b0, err: 1'b0, chk_bcd: 1'b1});
    #2 rst_n = 1'b1;
    drive(1'b1, 1'b1, 16'h1234, 1'b0);
    cyc("rst_restart_t0", frame_exp(16'h1234, 0, 1'b0, err_exp));
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    for (int t = 1; t < 25; t++) begin
      cyc($sformatf("rst_restart_t%0d", t), frame_exp(16'h1234, t, 1'b0, err_exp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
